// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: widths, IF packet layout, RV32I base opcodes, decode helpers.
package decode_stage_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int IF_INSTR_LSB = 0;
    localparam int IF_PC_LSB    = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    function automatic logic opc_legal(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic opc_uses_rs1(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_OP, OPC_BRANCH, OPC_JALR: return 1'b1;
            default:                                                        return 1'b0;
        endcase
    endfunction

    function automatic logic opc_uses_rs2(input logic [6:0] opc);
        case (opc)
            OPC_STORE, OPC_OP, OPC_BRANCH: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // R-type and unknown opcodes yield 0; U-type is already full width.
    function automatic logic [31:0] gen_imm(input logic [31:0] instr);
        logic [31:0] imm;
        imm = '0;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file, two combinational reads with write-through, one write port.
// Latency: reads are combinational; a write lands on the rising edge.
// Backpressure: none; contents are not reset and x0 always reads 0.
module decode_stage_regfile
    import decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] mem [32];

    always_ff @(posedge clk) begin
        if (wr_en && wr_addr != 5'd0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A write in the same cycle as a read returns the new value.
    always_comb begin
        rs1_data = mem[rs1_addr];
        rs2_data = mem[rs2_addr];
        if (wr_en && wr_addr != 5'd0 && wr_addr == rs1_addr) rs1_data = wr_data;
        if (wr_en && wr_addr != 5'd0 && wr_addr == rs2_addr) rs2_data = wr_data;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: immediate/illegal decode, register read, load-use interlock.
// Latency: 1 cycle from accepted fetch packet to registered o_id_* outputs.
// Backpressure: o_stall = i_stall | load-use hazard; a hazard inserts one bubble.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int IF_PKT_WIDTH = 64
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_if_pkt_valid,
    input  logic [IF_PKT_WIDTH-1:0] i_if_pkt_data,
    output logic                    o_stall,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_wb_en,
    input  logic [4:0]              i_wb_rd,
    input  logic [DATA_WIDTH-1:0]   i_wb_data,
    output logic                    o_id_valid,
    output logic [ADDR_WIDTH-1:0]   o_id_pc,
    output logic [31:0]             o_id_instr,
    output logic [31:0]             o_id_rs1_data,
    output logic [31:0]             o_id_rs2_data,
    output logic [31:0]             o_id_imm,
    output logic [4:0]              o_id_rd,
    output logic                    o_id_illegal
);

    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic [6:0]            opcode;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [DATA_WIDTH-1:0] rs1_rdata;
    logic [DATA_WIDTH-1:0] rs2_rdata;
    logic                  hazard;

    assign instr  = i_if_pkt_data[IF_INSTR_LSB +: 32];
    assign pc     = i_if_pkt_data[IF_PC_LSB +: ADDR_WIDTH];
    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    decode_stage_regfile u_regfile (
        .clk      (clk),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_rdata),
        .rs2_data (rs2_rdata),
        .wr_en    (i_wb_en),
        .wr_addr  (i_wb_rd),
        .wr_data  (i_wb_data)
    );

    // Load result is not available until after execute, so a dependent instruction waits one cycle.
    always_comb begin
        hazard = 1'b0;
        if (o_id_valid && o_id_instr[6:0] == OPC_LOAD && o_id_rd != 5'd0 && i_if_pkt_valid) begin
            hazard = (opc_uses_rs1(opcode) && rs1 == o_id_rd) ||
                     (opc_uses_rs2(opcode) && rs2 == o_id_rd);
        end
    end

    assign o_stall = i_stall | hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_id_valid    <= 1'b0;
            o_id_pc       <= '0;
            o_id_instr    <= '0;
            o_id_rs1_data <= '0;
            o_id_rs2_data <= '0;
            o_id_imm      <= '0;
            o_id_rd       <= '0;
            o_id_illegal  <= 1'b0;
        end else if (i_flush) begin
            o_id_valid <= 1'b0;
        end else if (i_stall) begin
            o_id_valid <= o_id_valid;
        end else if (hazard) begin
            o_id_valid <= 1'b0;
        end else begin
            o_id_valid    <= i_if_pkt_valid;
            o_id_pc       <= pc;
            o_id_instr    <= instr;
            o_id_rs1_data <= rs1_rdata;
            o_id_rs2_data <= rs2_rdata;
            o_id_imm      <= gen_imm(instr);
            o_id_rd       <= instr[11:7];
            o_id_illegal  <= ~opc_legal(opcode);
        end
    end

endmodule
